vote_result_display: RTL and testbench

// Downstream stage of the ballot box (Urna): once voting is closed (finish), snapshots the

---
 rtl/vote_result_display.sv | 201 ++++++++++++++++++++
 tb/tb_vote_result_display.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vote_result_display.sv
// Count-out stage of the voting machine: snapshots the totals when voting closes, converts
// them to BCD, decides the winner and rotates the three results across a 3-digit display.
module vote_result_display #(
  parameter int WIDTH = 8,
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             finish,
  input  logic [WIDTH-1:0] total_c1,
  input  logic [WIDTH-1:0] total_c2,
  input  logic [WIDTH-1:0] total_null,
  output logic             busy,
  output logic             done,
  output logic [1:0]       winner,
  output logic             tie,
  output logic [1:0]       page,
  output logic [3:0]       hund,
  output logic [3:0]       tens,
  output logic [3:0]       units,
  output logic [6:0]       seg_h,
  output logic [6:0]       seg_t,
  output logic [6:0]       seg_u
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int DW = $clog2(DWELL + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CONV,
    DECIDE,
    SHOW
  } state_t;

  state_t           state;
  logic             finish_q;
  logic [WIDTH-1:0] snap_c1;
  logic [WIDTH-1:0] snap_c2;
  logic [WIDTH-1:0] snap_null;
  logic [WIDTH-1:0] bin_sh;
  logic [11:0]      acc;
  logic [CW-1:0]    bit_cnt;
  logic [1:0]       sel;
  logic [11:0]      bcd_c1;
  logic [11:0]      bcd_c2;
  logic [11:0]      bcd_null;
  logic [DW-1:0]    dwell;

  logic [11:0]      acc_adj;
  logic [11:0]      acc_next;
  logic [1:0]       next_page;
  logic [11:0]      next_bcd;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Double-dabble step: correct every nibble >= 5 before the shift brings in the next bit.
  always_comb begin
    acc_adj = acc;
    for (int unsigned i = 0; i < 3; i++) begin
      if (acc[i*4 +: 4] >= 4'd5)
        acc_adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
    end
    acc_next = {acc_adj[10:0], bin_sh[WIDTH-1]};
  end

  always_comb begin
    next_page = (page == 2'd2) ? 2'd0 : page + 2'd1;
    case (next_page)
      2'd0:    next_bcd = bcd_c1;
      2'd1:    next_bcd = bcd_c2;
      default: next_bcd = bcd_null;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      finish_q  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      winner    <= 2'b00;
      tie       <= 1'b0;
      page      <= 2'd0;
      hund      <= '0;
      tens      <= '0;
      units     <= '0;
      seg_h     <= '1;
      seg_t     <= '1;
      seg_u     <= '1;
      snap_c1   <= '0;
      snap_c2   <= '0;
      snap_null <= '0;
      bin_sh    <= '0;
      acc       <= '0;
      bit_cnt   <= '0;
      sel       <= 2'd0;
      bcd_c1    <= '0;
      bcd_c2    <= '0;
      bcd_null  <= '0;
      dwell     <= '0;
    end else begin
      finish_q <= finish;
      case (state)
        IDLE: begin
          if (finish && !finish_q) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          snap_c1   <= total_c1;
          snap_c2   <= total_c2;
          snap_null <= total_null;
          bin_sh    <= total_c1;
          acc       <= '0;
          bit_cnt   <= '0;
          sel       <= 2'd0;
          state     <= CONV;
        end
        CONV: begin
          if (bit_cnt == CW'(WIDTH - 1)) begin
            bit_cnt <= '0;
            acc     <= '0;
            case (sel)
              2'd0:    bcd_c1   <= acc_next;
              2'd1:    bcd_c2   <= acc_next;
              default: bcd_null <= acc_next;
            endcase
            if (sel == 2'd2) begin
              state <= DECIDE;
            end else begin
              sel    <= sel + 2'd1;
              bin_sh <= (sel == 2'd0) ? snap_c2 : snap_null;
            end
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
            acc     <= acc_next;
            bin_sh  <= bin_sh << 1;
          end
        end
        DECIDE: begin
          if (snap_c1 > snap_c2) begin
            winner <= 2'b01;
            tie    <= 1'b0;
          end else if (snap_c2 > snap_c1) begin
            winner <= 2'b10;
            tie    <= 1'b0;
          end else begin
            winner <= 2'b00;
            tie    <= 1'b1;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          page  <= 2'd0;
          dwell <= '0;
          hund  <= bcd_c1[11:8];
          tens  <= bcd_c1[7:4];
          units <= bcd_c1[3:0];
          seg_h <= seg7(bcd_c1[11:8]);
          seg_t <= seg7(bcd_c1[7:4]);
          seg_u <= seg7(bcd_c1[3:0]);
          state <= SHOW;
        end
        SHOW: begin
          if (dwell == DW'(DWELL - 1)) begin
            dwell <= '0;
            page  <= next_page;
            hund  <= next_bcd[11:8];
            tens  <= next_bcd[7:4];
            units <= next_bcd[3:0];
            seg_h <= seg7(next_bcd[11:8]);
            seg_t <= seg7(next_bcd[7:4]);
            seg_u <= seg7(next_bcd[3:0]);
          end else begin
            dwell <= dwell + DW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vote_result_display.sv
// Directed bench for vote_result_display: reset, winner/tie decisions, BCD pages,
// page rotation, reset during conversion and snapshot isolation.
module tb_vote_result_display;

  logic       clk;
  logic       rst;
  logic       finish;
  logic [7:0] total_c1;
  logic [7:0] total_c2;
  logic [7:0] total_null;
  logic       busy;
  logic       done;
  logic [1:0] winner;
  logic       tie;
  logic [1:0] page;
  logic [3:0] hund;
  logic [3:0] tens;
  logic [3:0] units;
  logic [6:0] seg_h;
  logic [6:0] seg_t;
  logic [6:0] seg_u;

  int checks = 0;
  int errors = 0;

  vote_result_display #(.WIDTH(8), .DWELL(4)) dut (
    .clk(clk), .rst(rst), .finish(finish),
    .total_c1(total_c1), .total_c2(total_c2), .total_null(total_null),
    .busy(busy), .done(done), .winner(winner), .tie(tie), .page(page),
    .hund(hund), .tens(tens), .units(units),
    .seg_h(seg_h), .seg_t(seg_t), .seg_u(seg_u)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  // Raises finish, then waits 26 edges (edge 1 samples the rise), i.e. one edge short of done.
  task automatic launch(input logic [7:0] c1, input logic [7:0] c2, input logic [7:0] n,
                        input bit change_after_load);
    total_c1 = c1; total_c2 = c2; total_null = n;
    finish = 1'b0;
    tick(1);
    finish = 1'b1;
    tick(2);
    if (change_after_load) begin
      total_c1 = 8'd9; total_c2 = 8'd9; total_null = 8'd9;
    end
    tick(24);
  endtask

  task automatic test_reset();
    finish = 1'b1;
    total_c1 = 8'd0; total_c2 = 8'd0; total_null = 8'd0;
    do_reset();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || winner !== 2'b00 || tie !== 1'b0 || page !== 2'd0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b done=%b winner=%b tie=%b page=%0d, want 0/0/00/0/0",
               busy, done, winner, tie, page);
    end
    checks++;
    if ({hund, tens, units} !== 12'h000 || {seg_h, seg_t, seg_u} !== {3{7'h7F}}) begin
      errors++;
      $display("FAIL reset_disp: digits=%h segs=%h/%h/%h, want 000 7f/7f/7f",
               {hund, tens, units}, seg_h, seg_t, seg_u);
    end
    // finish held high through reset must not start a count-out
    tick(5);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_start: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_c2_wins();
    do_reset();
    launch(8'd2, 8'd3, 8'd1, 1'b0);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL c2_before_done: busy=%b done=%b, want 1/0", busy, done);
    end
    tick(1);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL c2_latency: done=%b busy=%b, want 1/0", done, busy);
    end
    checks++;
    if (winner !== 2'b10 || tie !== 1'b0) begin
      errors++;
      $display("FAIL c2_winner: winner=%b tie=%b, want 10/0", winner, tie);
    end
    checks++;
    if (page !== 2'd0 || {hund, tens, units} !== 12'h002 || seg_u !== 7'b0100100 ||
        seg_h !== 7'b1000000) begin
      errors++;
      $display("FAIL c2_page0: page=%0d digits=%h seg_h=%b seg_u=%b, want 0 002 1000000 0100100",
               page, {hund, tens, units}, seg_h, seg_u);
    end
  endtask

  task automatic test_tie();
    do_reset();
    launch(8'd5, 8'd5, 8'd0, 1'b0);
    tick(1);
    checks++;
    if (winner !== 2'b00 || tie !== 1'b1) begin
      errors++;
      $display("FAIL tie_decide: winner=%b tie=%b, want 00/1", winner, tie);
    end
    tick(4);
    checks++;
    if (page !== 2'd1 || {hund, tens, units} !== 12'h005 || seg_u !== 7'b0010010) begin
      errors++;
      $display("FAIL tie_page1: page=%0d digits=%h seg_u=%b, want 1 005 0010010",
               page, {hund, tens, units}, seg_u);
    end
  endtask

  task automatic test_rotation();
    do_reset();
    launch(8'd255, 8'd0, 8'd100, 1'b0);
    tick(1);
    checks++;
    if (winner !== 2'b01 || page !== 2'd0 || {hund, tens, units} !== 12'h255 ||
        {seg_h, seg_t, seg_u} !== {7'b0100100, 7'b0010010, 7'b0010010}) begin
      errors++;
      $display("FAIL rot_c1: winner=%b page=%0d digits=%h segs=%b/%b/%b, want 01 0 255",
               winner, page, {hund, tens, units}, seg_h, seg_t, seg_u);
    end
    tick(3);
    checks++;
    if (page !== 2'd0) begin
      errors++;
      $display("FAIL rot_dwell: page=%0d after 3 cycles, want 0", page);
    end
    tick(1);
    checks++;
    if (page !== 2'd1 || {hund, tens, units} !== 12'h000 || seg_u !== 7'b1000000) begin
      errors++;
      $display("FAIL rot_c2: page=%0d digits=%h seg_u=%b, want 1 000 1000000",
               page, {hund, tens, units}, seg_u);
    end
    tick(4);
    checks++;
    if (page !== 2'd2 || {hund, tens, units} !== 12'h100 ||
        {seg_h, seg_t, seg_u} !== {7'b1111001, 7'b1000000, 7'b1000000}) begin
      errors++;
      $display("FAIL rot_null: page=%0d digits=%h segs=%b/%b/%b, want 2 100",
               page, {hund, tens, units}, seg_h, seg_t, seg_u);
    end
    tick(4);
    checks++;
    if (page !== 2'd0 || {hund, tens, units} !== 12'h255 || done !== 1'b1) begin
      errors++;
      $display("FAIL rot_wrap: page=%0d digits=%h done=%b, want 0 255 1",
               page, {hund, tens, units}, done);
    end
  endtask

  task automatic test_reset_mid_conv();
    do_reset();
    total_c1 = 8'd7; total_c2 = 8'd4; total_null = 8'd3;
    finish = 1'b0;
    tick(1);
    finish = 1'b1;
    tick(12);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || {seg_h, seg_t, seg_u} !== {3{7'h7F}}) begin
      errors++;
      $display("FAIL midrst_state: busy=%b done=%b segs=%h/%h/%h, want 0 0 blank",
               busy, done, seg_h, seg_t, seg_u);
    end
    tick(30);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_no_restart: busy=%b done=%b, want 0/0", busy, done);
    end
    launch(8'd7, 8'd4, 8'd3, 1'b0);
    tick(1);
    checks++;
    if (done !== 1'b1 || winner !== 2'b01 || {hund, tens, units} !== 12'h007) begin
      errors++;
      $display("FAIL midrst_restart: done=%b winner=%b digits=%h, want 1 01 007",
               done, winner, {hund, tens, units});
    end
  endtask

  task automatic test_snapshot();
    do_reset();
    launch(8'd42, 8'd17, 8'd8, 1'b1);
    tick(1);
    checks++;
    if (winner !== 2'b01 || tie !== 1'b0 || {hund, tens, units} !== 12'h042) begin
      errors++;
      $display("FAIL snap_c1: winner=%b tie=%b digits=%h, want 01 0 042",
               winner, tie, {hund, tens, units});
    end
    tick(4);
    checks++;
    if ({hund, tens, units} !== 12'h017) begin
      errors++;
      $display("FAIL snap_c2: digits=%h, want 017", {hund, tens, units});
    end
    tick(4);
    checks++;
    if ({hund, tens, units} !== 12'h008 || seg_u !== 7'b0000000) begin
      errors++;
      $display("FAIL snap_null: digits=%h seg_u=%b, want 008 0000000",
               {hund, tens, units}, seg_u);
    end
  endtask

  initial begin
    rst = 1'b1;
    finish = 1'b0;
    total_c1 = '0; total_c2 = '0; total_null = '0;
    test_reset();
    test_c2_wins();
    test_tie();
    test_rotation();
    test_reset_mid_conv();
    test_snapshot();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
